sram_arb2: RTL and testbench
============================

# sram_arb2

Two-requester round-robin arbiter that shares one `sram_sp` single-port synchronous SRAM between requester A and requester B. It sits directly in front of the `sram_sp` instance and owns all of its control ports: `we`, `re`, `add` and `data_in`. Each cycle it grants at most one access, rejects out-of-range addresses, and returns read data with a per-port valid pulse.

## Interface
Parameters:
- `depth`, 10: number of SRAM words; must match the attached `sram_sp`.
- `width`, 8: data width in bits; must match the attached `sram_sp`.
- `AW` (localparam), `$clog2(depth)`: address width.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `a_req`  in  1  requester A access request; held until granted.
- `a_we`  in  1  1 = write, 0 = read; qualified by `a_req`.
- `a_add`  in  AW  requester A word address.
- `a_wdata`  in  width  requester A write data.
- `a_gnt`  out  1  A's access is accepted this cycle.
- `a_rvalid`  out  1  A's read data is valid this cycle.
- `a_rdata`  out  width  A's read data; 0 when `a_rvalid`=0.
- `a_err`  out  1  one-cycle pulse: A's granted access was out of range.
- `b_req`, `b_we`, `b_add`, `b_wdata`, `b_gnt`, `b_rvalid`, `b_rdata`, `b_err`: same as the A ports, for requester B.
- `mem_we`  out  1  to `sram_sp.we`.
- `mem_re`  out  1  to `sram_sp.re`.
- `mem_add`  out  AW  to `sram_sp.add`.
- `mem_data_in`  out  width  to `sram_sp.data_in`.
- `mem_data_out`  in  width  from `sram_sp.data_out`.

## Operation
- **State registers**
  - `last`: 1 bit, the last port granted. Reset value is B, so A wins the first contention.
  - `rd_pend`: 2 bits, one per port, read-return pipeline.
  - `err_pend`: 2 bits, one per port.
- **Grant logic** (combinational from `req`, `last`, `rst`):
  - Only one port requesting: that port is granted.
  - Both ports requesting: the port ≠ `last` is granted.
  - `last` updates to the granted port on the clock edge.
  - No grant while `rst`=1.
- **Handshake**
  - The access transfers on the rising edge that ends a cycle with `x_req`=1 and `x_gnt`=1.
  - A requester may change `add`, `we` and `wdata` only after that edge.
  - A request that is not granted must be held stable.
- **Mem drive in the grant cycle**
  - `mem_add` = granted `add`.
  - `mem_data_in` = granted `wdata`.
  - `mem_we` = granted `we`.
  - `mem_re` = !granted `we`.
  - With no grant: all `mem_*` outputs are 0.
- **Range check**
  - If the granted `add` ≥ `depth`, the access is still granted and consumes its slot and `last` update.
  - `mem_we` and `mem_re` are forced to 0 for that access.
  - `x_err` pulses in the next cycle.
  - No `x_rvalid` is produced for that access.
- **Read return**
  - `sram_sp` presents read data one cycle after `re` is sampled.
  - A read granted in cycle N sets `rd_pend[x]`.
  - In cycle N+1: `x_rvalid`=1 and `x_rdata` = `mem_data_out`.
  - `x_rdata` is 0 otherwise.
- **Write:** complete at the grant edge; no response signal.

## Timing
- Throughput: one access per cycle total, back-to-back grants allowed.
- Under continuous contention, grants alternate strictly A, B, A, B.
- Read latency: grant cycle N → `rvalid` in N+1.
- Error latency: grant cycle N → `err` in N+1.
- Write then read of the same address in consecutive cycles returns the new data.
- A read granted in N followed by a write to the same address granted in N+1: the read returns the old data.
- **Reset** (asynchronous, immediate):
  - `last` ← B; `rd_pend` and `err_pend` ← 0.
  - All outputs are 0 while `rst`=1: `gnt`, `rvalid`, `rdata`, `err`, `mem_*`.
  - A read in flight when `rst` asserts is dropped; no `rvalid` after `rst` deasserts.
  - SRAM contents are not cleared.
- The first edge after `rst` deasserts may carry a grant.

## Test plan
- **Reset mid-read:** grant an A read, assert `rst` before the next edge, release it two cycles later → `a_rvalid` never rises; all outputs 0 during reset; A wins the first contention after release.
- **Write then read, single requester:** A writes 25 to add 0, then A reads add 0 → `a_gnt` in both cycles; `a_rvalid`=1 with `a_rdata`=25 exactly one cycle after the read grant; `b_*` outputs stay 0.
- **Contention fairness:** from reset, A and B request continuously (A writes 0x11 to add 1, B writes 0x22 to add 2, then both read) → grants follow A, B, A, B; reads return 0x11 to A and 0x22 to B, each one cycle after its grant.
- **Out of range:** `depth`=10, B reads add 12 → `b_gnt`=1 with `mem_re`=0 and `mem_we`=0; `b_err`=1 for one cycle next cycle; `b_rvalid` stays 0; B's next request is served normally.
- **Ordering across ports:**
  - A writes 0x55 to add 3, then B reads add 3 in the next grant → `b_rdata`=0x55.
  - B reads add 3, then A writes 0xAA to add 3 → B gets 0x55.
- **Idle partner:** A requests every cycle for 8 cycles while B is idle → `a_gnt`=1 in all 8 cycles; reads return in order, one per cycle.

Source files
------------

// File: rtl/sram_arb2.sv
// sram_arb2: round-robin arbiter sharing one sram_sp between requesters A and B.
// Out-of-range accesses are granted but suppressed at the SRAM and flagged a cycle later.
module sram_arb2 #(
  parameter int unsigned depth = 10,
  parameter int unsigned width = 8,
  localparam int unsigned AW = $clog2(depth)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_req,
  input  logic             a_we,
  input  logic [AW-1:0]    a_add,
  input  logic [width-1:0] a_wdata,
  output logic             a_gnt,
  output logic             a_rvalid,
  output logic [width-1:0] a_rdata,
  output logic             a_err,
  input  logic             b_req,
  input  logic             b_we,
  input  logic [AW-1:0]    b_add,
  input  logic [width-1:0] b_wdata,
  output logic             b_gnt,
  output logic             b_rvalid,
  output logic [width-1:0] b_rdata,
  output logic             b_err,
  output logic             mem_we,
  output logic             mem_re,
  output logic [AW-1:0]    mem_add,
  output logic [width-1:0] mem_data_in,
  input  logic [width-1:0] mem_data_out
);

  localparam logic PortA = 1'b0;
  localparam logic PortB = 1'b1;

  logic       r_last;
  logic [1:0] r_rd_pend;
  logic [1:0] r_err_pend;

  logic             w_a_gnt;
  logic             w_b_gnt;
  logic             w_any_gnt;
  logic             w_we;
  logic [AW-1:0]    w_add;
  logic [width-1:0] w_wdata;
  logic             w_in_range;
  logic             w_rd_ok;

  // Under contention the port that did not win last time takes this slot.
  always_comb begin
    w_a_gnt = 1'b0;
    w_b_gnt = 1'b0;
    if (!rst) begin
      if (a_req && b_req) begin
        w_a_gnt = (r_last == PortB);
        w_b_gnt = (r_last == PortA);
      end else begin
        w_a_gnt = a_req;
        w_b_gnt = b_req;
      end
    end
  end

  assign w_any_gnt = w_a_gnt | w_b_gnt;

  always_comb begin
    w_we    = a_we;
    w_add   = a_add;
    w_wdata = a_wdata;
    if (w_b_gnt) begin
      w_we    = b_we;
      w_add   = b_add;
      w_wdata = b_wdata;
    end
  end

  assign w_in_range = (32'(w_add) < depth);
  assign w_rd_ok    = w_any_gnt & w_in_range & ~w_we;

  assign mem_we      = w_any_gnt & w_in_range & w_we;
  assign mem_re      = w_rd_ok;
  assign mem_add     = w_any_gnt ? w_add : '0;
  assign mem_data_in = w_any_gnt ? w_wdata : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last     <= PortB;
      r_rd_pend  <= '0;
      r_err_pend <= '0;
    end else begin
      if (w_any_gnt) begin
        r_last <= w_b_gnt;
      end
      r_rd_pend  <= {w_b_gnt & w_rd_ok, w_a_gnt & w_rd_ok};
      r_err_pend <= {w_b_gnt & ~w_in_range, w_a_gnt & ~w_in_range};
    end
  end

  assign a_gnt    = w_a_gnt;
  assign b_gnt    = w_b_gnt;
  assign a_rvalid = r_rd_pend[0] & ~rst;
  assign b_rvalid = r_rd_pend[1] & ~rst;
  assign a_rdata  = a_rvalid ? mem_data_out : '0;
  assign b_rdata  = b_rvalid ? mem_data_out : '0;
  assign a_err    = r_err_pend[0] & ~rst;
  assign b_err    = r_err_pend[1] & ~rst;

endmodule

// File: tb/tb_sram_arb2.sv
// Randomized + directed bench for sram_arb2 with an sram_sp model and a scoreboard
// fed by a transaction-level reference (memory array, last-winner bit, response queues).
module tb_sram_arb2;

  localparam int unsigned Depth = 10;
  localparam int unsigned Width = 8;
  localparam int unsigned AW    = $clog2(Depth);

  typedef struct {
    bit               req;
    bit               we;
    logic [AW-1:0]    add;
    logic [Width-1:0] wdata;
  } item_t;

  typedef struct {
    int               due;
    bit               is_err;
    logic [Width-1:0] data;
  } resp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             a_req, a_we, b_req, b_we;
  logic [AW-1:0]    a_add, b_add;
  logic [Width-1:0] a_wdata, b_wdata;
  logic             a_gnt, a_rvalid, a_err, b_gnt, b_rvalid, b_err;
  logic [Width-1:0] a_rdata, b_rdata;
  logic             mem_we, mem_re;
  logic [AW-1:0]    mem_add;
  logic [Width-1:0] mem_data_in;
  logic [Width-1:0] mem_data_out = '0;

  int n_chk  = 0;
  int n_fail = 0;
  int ncyc   = 0;

  item_t a_q[$];
  item_t b_q[$];
  item_t cur_a, cur_b;
  bit    a_took, b_took;

  resp_t            exp_a_q[$];
  resp_t            exp_b_q[$];
  logic [Width-1:0] ref_mem [Depth] = '{default: '0};
  bit               ref_last = 1'b1;  // 1 = B won last

  logic [Width-1:0] sram [Depth] = '{default: '0};

  always #5 clk = ~clk;

  sram_arb2 #(.depth(Depth), .width(Width)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_add(a_add), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata), .a_err(a_err),
    .b_req(b_req), .b_we(b_we), .b_add(b_add), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata), .b_err(b_err),
    .mem_we(mem_we), .mem_re(mem_re), .mem_add(mem_add),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
  );

  // sram_sp: synchronous write, registered read data one cycle after re.
  always @(posedge clk) begin
    if (mem_we && 32'(mem_add) < Depth) sram[mem_add] <= mem_data_in;
    if (mem_re && 32'(mem_add) < Depth) mem_data_out <= sram[mem_add];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, ncyc);
    end
  endtask

  task automatic check_port(input bit p, input logic rv, input logic [Width-1:0] rd,
                            input logic er);
    resp_t            f;
    bit               e_rv = 1'b0;
    bit               e_er = 1'b0;
    logic [Width-1:0] e_rd = '0;
    bit               have;
    have = p ? (exp_b_q.size() > 0) : (exp_a_q.size() > 0);
    if (have) begin
      f = p ? exp_b_q[0] : exp_a_q[0];
      if (f.due == ncyc) begin
        e_rv = !f.is_err;
        e_er = f.is_err;
        e_rd = f.is_err ? '0 : f.data;
        if (p) void'(exp_b_q.pop_front());
        else   void'(exp_a_q.pop_front());
      end
    end
    chk($sformatf("%s_rvalid", p ? "b" : "a"), 32'(rv), 32'(e_rv));
    chk($sformatf("%s_rdata", p ? "b" : "a"), 32'(rd), 32'(e_rd));
    chk($sformatf("%s_err", p ? "b" : "a"), 32'(er), 32'(e_er));
  endtask

  // Monitor / scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    bit               ea, eb, inr;
    item_t            g;
    resp_t            r;
    logic             e_we, e_re;
    logic [AW-1:0]    e_add;
    logic [Width-1:0] e_din;
    ncyc++;
    if (rst) begin
      chk("reset_outputs_zero",
          32'(|{a_gnt, a_rvalid, a_rdata, a_err, b_gnt, b_rvalid, b_rdata, b_err,
                mem_we, mem_re, mem_add, mem_data_in}), 32'd0);
      exp_a_q.delete();
      exp_b_q.delete();
      ref_last = 1'b1;
      a_took   = 1'b0;
      b_took   = 1'b0;
    end else begin
      check_port(1'b0, a_rvalid, a_rdata, a_err);
      check_port(1'b1, b_rvalid, b_rdata, b_err);
      if (cur_a.req && cur_b.req) begin
        ea = ref_last;
        eb = !ref_last;
      end else begin
        ea = cur_a.req;
        eb = cur_b.req;
      end
      chk("a_gnt", 32'(a_gnt), 32'(ea));
      chk("b_gnt", 32'(b_gnt), 32'(eb));
      e_we = 1'b0; e_re = 1'b0; e_add = '0; e_din = '0;
      if (ea || eb) begin
        g     = ea ? cur_a : cur_b;
        inr   = (32'(g.add) < Depth);
        e_we  = inr && g.we;
        e_re  = inr && !g.we;
        e_add = g.add;
        e_din = g.wdata;
        r.due = ncyc + 1;
        r.is_err = !inr;
        r.data = '0;
        if (inr && g.we) ref_mem[g.add] = g.wdata;
        if (inr && !g.we) r.data = ref_mem[g.add];
        if (!inr || !g.we) begin
          if (ea) exp_a_q.push_back(r);
          else    exp_b_q.push_back(r);
        end
        ref_last = eb;
      end
      chk("mem_we", 32'(mem_we), 32'(e_we));
      chk("mem_re", 32'(mem_re), 32'(e_re));
      chk("mem_add", 32'(mem_add), 32'(e_add));
      chk("mem_data_in", 32'(mem_data_in), 32'(e_din));
      a_took = ea;
      b_took = eb;
    end
  end

  function automatic item_t mk(input bit req, input bit we, input int add, input int data);
    item_t it;
    it.req   = req;
    it.we    = we;
    it.add   = AW'(add);
    it.wdata = Width'(data);
    return it;
  endfunction

  task automatic apply();
    a_req = cur_a.req; a_we = cur_a.we; a_add = cur_a.add; a_wdata = cur_a.wdata;
    b_req = cur_b.req; b_we = cur_b.we; b_add = cur_b.add; b_wdata = cur_b.wdata;
  endtask

  // An ungranted request is held; a granted or idle slot advances to the next item.
  task automatic step();
    @(posedge clk);
    #1;
    if (!cur_a.req || a_took) cur_a = (a_q.size() > 0) ? a_q.pop_front() : mk(0, 0, 0, 0);
    if (!cur_b.req || b_took) cur_b = (b_q.size() > 0) ? b_q.pop_front() : mk(0, 0, 0, 0);
    a_took = 1'b0;
    b_took = 1'b0;
    apply();
  endtask

  task automatic run_idle(input int max);
    bit done = 1'b0;
    for (int n = 0; n < max && !done; n++) begin
      step();
      done = (a_q.size() == 0) && (b_q.size() == 0) && !cur_a.req && !cur_b.req &&
             (exp_a_q.size() == 0) && (exp_b_q.size() == 0);
    end
    if (!done) chk("drain_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    rst   = 1'b1;
    cur_a = mk(0, 0, 0, 0);
    cur_b = mk(0, 0, 0, 0);
    apply();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset while an A read is in flight: the read must be dropped.
    a_q.push_back(mk(1, 0, 0, 0));
    step();
    @(negedge clk);
    #1 rst = 1'b1;
    step();
    step();
    rst = 1'b0;

    // Contention from reset: A, B, A, B.
    a_q.push_back(mk(1, 1, 1, 8'h11)); a_q.push_back(mk(1, 0, 1, 0));
    b_q.push_back(mk(1, 1, 2, 8'h22)); b_q.push_back(mk(1, 0, 2, 0));
    run_idle(50);

    // Single requester write then read.
    a_q.push_back(mk(1, 1, 0, 25)); a_q.push_back(mk(1, 0, 0, 0));
    run_idle(50);

    // Out of range, then a normal access.
    b_q.push_back(mk(1, 0, 12, 0)); b_q.push_back(mk(1, 0, 2, 0));
    run_idle(50);

    // Cross-port ordering in both directions.
    a_q.push_back(mk(1, 1, 3, 8'h55));
    b_q.push_back(mk(0, 0, 0, 0)); b_q.push_back(mk(1, 0, 3, 0));
    run_idle(50);
    b_q.push_back(mk(1, 0, 3, 0));
    a_q.push_back(mk(0, 0, 0, 0)); a_q.push_back(mk(1, 1, 3, 8'hAA));
    run_idle(50);

    // Idle partner: eight back-to-back A accesses.
    for (int i = 0; i < 8; i++) a_q.push_back(mk(1, i % 2, i, 8'h40 + i));
    run_idle(50);

    // Randomized traffic, including out-of-range addresses.
    for (int i = 0; i < 400; i++) begin
      a_q.push_back(mk($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                       int'($urandom_range(0, 15)), int'($urandom_range(0, 255))));
      b_q.push_back(mk($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                       int'($urandom_range(0, 15)), int'($urandom_range(0, 255))));
    end
    run_idle(3000);

    step();
    step();
    chk("a_resp_queue_empty", 32'(exp_a_q.size()), 32'd0);
    chk("b_resp_queue_empty", 32'(exp_b_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
